aibnd_sync_seq: RTL and testbench

AIBND_SYNC_SEQ -- requirements
Module: aibnd_sync_seq

---
 rtl/aibnd_sync_seq_if.sv | 22 ++
 rtl/aibnd_sync_seq.sv | 160 ++++++++++++++++
 tb/tb_aibnd_sync_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aibnd_sync_seq_if.sv
// Control/status bundle between the sync-bank sequencer (slave) and its controller (master).
interface aibnd_sync_seq_if;
  logic       en;
  logic       scan_req;
  logic [7:0] scan_len;
  logic       rb_out;
  logic       se_n_out;
  logic       sync_valid;
  logic       scan_ack;
  logic       scan_done;
  logic [2:0] state;

  modport master (
    output en, scan_req, scan_len,
    input  rb_out, se_n_out, sync_valid, scan_ack, scan_done, state
  );

  modport slave (
    input  en, scan_req, scan_len,
    output rb_out, se_n_out, sync_valid, scan_ack, scan_done, state
  );
endinterface

// File: rtl/aibnd_sync_seq.sv
// Reset/settle/scan sequencer for a bank of 2-FF synchronizers; all outputs registered.
// Define AIBND_SYNC_SEQ_SCAN_EN to build the scan-shift path (SCAN state, shift counter, pending request).
module aibnd_sync_seq #(
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  aibnd_sync_seq_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    SETTLE   = 3'd2,
    RUN      = 3'd3,
    SCAN     = 3'd4
  } state_t;

  localparam logic [7:0] RST_LAST    = 8'(RST_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t     st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rb_q, vld_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

`ifdef AIBND_SYNC_SEQ_SCAN_EN
  logic [8:0] scnt_q, scnt_d;
  logic       pend_q, pend_d;
  logic       se_n_q, ack_q, done_q, done_d;

  // A length of zero encodes the full 256-cycle shift.
  function automatic logic [8:0] scan_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{bus.scan_req, bus.scan_len};
`endif

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
`ifdef AIBND_SYNC_SEQ_SCAN_EN
    scnt_d = scnt_q;
    pend_d = pend_q;
    done_d = 1'b0;
`endif
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en) st_d = RST_HOLD;
`ifdef AIBND_SYNC_SEQ_SCAN_EN
        // Scan has priority over a simultaneous enable.
        if (bus.scan_req) begin
          st_d   = SCAN;
          scnt_d = scan_count(bus.scan_len);
        end
`endif
      end
      RST_HOLD: begin
        if (!bus.en) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q >= RST_LAST) begin
          st_d  = SETTLE;
          cnt_d = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      SETTLE: begin
        if (!bus.en) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q >= SETTLE_LAST) begin
          st_d  = RUN;
          cnt_d = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!bus.en) begin
          st_d = IDLE;
        end
`ifdef AIBND_SYNC_SEQ_SCAN_EN
        else if (bus.scan_req || pend_q) begin
          st_d   = SCAN;
          scnt_d = scan_count(bus.scan_len);
        end
`endif
      end
`ifdef AIBND_SYNC_SEQ_SCAN_EN
      // Shift runs to completion regardless of en; the flops are reseeded afterwards.
      SCAN: begin
        if (scnt_q <= 9'd1) begin
          done_d = 1'b1;
          scnt_d = '0;
          cnt_d  = '0;
          st_d   = bus.en ? RST_HOLD : IDLE;
        end else begin
          scnt_d = scnt_q - 9'd1;
        end
      end
`endif
      default: st_d = IDLE;
    endcase
`ifdef AIBND_SYNC_SEQ_SCAN_EN
    if (bus.scan_req && ((st_q == RST_HOLD) || (st_q == SETTLE))) pend_d = 1'b1;
    if ((st_d == IDLE) || (st_d == SCAN)) pend_d = 1'b0;
`endif
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      rb_q   <= 1'b0;
      vld_q  <= 1'b0;
`ifdef AIBND_SYNC_SEQ_SCAN_EN
      scnt_q <= '0;
      pend_q <= 1'b0;
      se_n_q <= 1'b1;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rb_q   <= (st_d == SETTLE) || (st_d == RUN) || (st_d == SCAN);
      vld_q  <= (st_d == RUN);
`ifdef AIBND_SYNC_SEQ_SCAN_EN
      scnt_q <= scnt_d;
      pend_q <= pend_d;
      se_n_q <= (st_d != SCAN);
      ack_q  <= (st_d == SCAN);
      done_q <= done_d;
`endif
    end
  end

  assign bus.rb_out     = rb_q;
  assign bus.sync_valid = vld_q;
  assign bus.state      = st_q;
`ifdef AIBND_SYNC_SEQ_SCAN_EN
  assign bus.se_n_out   = se_n_q;
  assign bus.scan_ack   = ack_q;
  assign bus.scan_done  = done_q;
`else
  assign bus.se_n_out   = 1'b1;
  assign bus.scan_ack   = 1'b0;
  assign bus.scan_done  = 1'b0;
`endif
endmodule

// File: tb/tb_aibnd_sync_seq.sv
// Bench for aibnd_sync_seq: timing table, directed scan corner cases, then random traffic vs. a phase/countdown model.
module tb_aibnd_sync_seq;
  localparam int RST_CYC    = 4;
  localparam int SETTLE_CYC = 4;
`ifdef AIBND_SYNC_SEQ_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  aibnd_sync_seq_if ifc();

  aibnd_sync_seq #(.RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // {rb_out, se_n_out, sync_valid, scan_ack, scan_done, state[2:0]}
  wire [7:0] outv = {ifc.rb_out, ifc.se_n_out, ifc.sync_valid, ifc.scan_ack, ifc.scan_done, ifc.state};

  int nvec = 0;
  int nerr = 0;

  // Model: phase number, cycles left in the timed phase, shift cycles left, pending scan, done pulse.
  int m_ph, m_left, m_sleft;
  bit m_pend, m_done;

  typedef struct {
    logic       en;
    logic       req;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[12];

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b (rb,se_n,vld,ack,done,state)", nm, act, exp);
    end
  endfunction

  function automatic void chk_int(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [7:0] v;
    v = {(m_ph == 2) || (m_ph == 3) || (m_ph == 4), m_ph != 4, m_ph == 3, m_ph == 4, m_done, 3'(m_ph)};
    return v;
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_left = 0; m_sleft = 0; m_pend = 1'b0; m_done = 1'b0;
  endfunction

  function automatic void enter_scan();
    m_ph    = 4;
    m_sleft = (ifc.scan_len == 8'd0) ? 256 : int'(ifc.scan_len);
    m_pend  = 1'b0;
  endfunction

  function automatic void model_step();
    m_done = 1'b0;
    case (m_ph)
      0: begin
        if (SCAN_ON && ifc.scan_req) enter_scan();
        else if (ifc.en) begin m_ph = 1; m_left = RST_CYC; end
      end
      1, 2: begin
        if (!ifc.en) begin
          m_ph = 0; m_pend = 1'b0;
        end else begin
          if (SCAN_ON && ifc.scan_req) m_pend = 1'b1;
          m_left--;
          if (m_left == 0) begin
            if (m_ph == 1) begin m_ph = 2; m_left = SETTLE_CYC; end
            else m_ph = 3;
          end
        end
      end
      3: begin
        if (!ifc.en) begin m_ph = 0; m_pend = 1'b0; end
        else if (SCAN_ON && (ifc.scan_req || m_pend)) enter_scan();
      end
      default: begin
        m_sleft--;
        if (m_sleft == 0) begin
          m_done = 1'b1;
          m_pend = 1'b0;
          if (ifc.en) begin m_ph = 1; m_left = RST_CYC; end
          else m_ph = 0;
        end
      end
    endcase
  endfunction

  task automatic step(input string nm);
    model_step();
    @(posedge clk); #1;
    chk(nm, outv, exp_vec());
  endtask

  task automatic do_reset();
    ifc.en = 1'b0; ifc.scan_req = 1'b0;
    rst = 1'b1; #2;
    chk("rst_async", outv, 8'b0100_0000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic to_run(input string nm);
    int g;
    ifc.en = 1'b1;
    g = 0;
    while (!ifc.sync_valid && g < 20) begin step(nm); g++; end
    chk_int({nm, "_reached_run"}, int'(ifc.sync_valid), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, cyc, guard, vcnt;
    logic prev_v;

    ifc.en = 1'b0; ifc.scan_req = 1'b0; ifc.scan_len = 8'd0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tbl[i].en  = (i < 10);
      tbl[i].req = SCAN_ON ? 1'b0 : 1'(i % 2);
      if (i < 4)       tbl[i].exp = 8'b0100_0001;
      else if (i < 8)  tbl[i].exp = 8'b1100_0010;
      else if (i < 10) tbl[i].exp = 8'b1110_0011;
      else             tbl[i].exp = 8'b0100_0000;
    end

    #1;
    do_reset();

    // Power-up timing; in the non-scan build scan_req toggles throughout.
    for (int i = 0; i < 12; i++) begin
      ifc.en = tbl[i].en; ifc.scan_req = tbl[i].req;
      model_step();
      @(posedge clk); #1;
      chk($sformatf("tbl%0d", i), outv, tbl[i].exp);
    end
    ifc.scan_req = 1'b0;

    // en dropped in SETTLE: IDLE with rb_out low on the next edge.
    do_reset();
    ifc.en = 1'b1;
    for (int i = 0; i < 6; i++) step("settle_walk");
    chk("in_settle", outv, 8'b1100_0010);
    ifc.en = 1'b0;
    step("settle_drop");
    chk("settle_drop_idle", outv, 8'b0100_0000);

    if (SCAN_ON) begin
      // Scan from RUN, len 3, len change mid-shift ignored.
      do_reset();
      to_run("s34");
      ifc.scan_req = 1'b1; ifc.scan_len = 8'd3;
      step("s34_enter");
      acks = 0; guard = 0;
      while (ifc.scan_ack && guard < 300) begin
        acks++; guard++; ifc.scan_len = 8'd7; step("s34_shift");
      end
      chk_int("s34_ack_cycles", acks, 3);
      chk("s34_done", outv, 8'b0100_1001);
      ifc.scan_req = 1'b0;
      cyc = 0;
      while (!ifc.sync_valid && cyc < 40) begin step("s34_reseed"); cyc++; end
      chk_int("s34_valid_delay", cyc, 8);

      // scan_len = 0 gives 256 shift cycles and a single done pulse.
      ifc.scan_req = 1'b1; ifc.scan_len = 8'd0;
      step("s35_enter");
      acks = 0; guard = 0;
      while (ifc.scan_ack && guard < 300) begin acks++; guard++; step("s35_shift"); end
      chk_int("s35_ack_cycles", acks, 256);
      chk_int("s35_done", int'(ifc.scan_done), 1);
      ifc.scan_req = 1'b0;
      step("s35_after");
      chk_int("s35_done_single", int'(ifc.scan_done), 0);

      // Request in RST_HOLD is deferred until RUN; RUN lasts exactly one cycle.
      do_reset();
      ifc.en = 1'b1; ifc.scan_len = 8'd2;
      step("s36_hold"); step("s36_hold");
      ifc.scan_req = 1'b1;
      vcnt = 0; prev_v = 1'b0; guard = 0;
      while (!ifc.scan_ack && guard < 30) begin
        prev_v = ifc.sync_valid;
        step("s36_wait");
        if (ifc.sync_valid) vcnt++;
        guard++;
      end
      chk_int("s36_valid_cycles", vcnt, 1);
      chk_int("s36_run_before_scan", int'(prev_v), 1);
      guard = 0;
      while (ifc.scan_ack && guard < 10) begin guard++; step("s36_shift"); end
      ifc.scan_req = 1'b0;

      // en dropped mid-shift: shift completes, then IDLE.
      to_run("s37");
      ifc.scan_req = 1'b1; ifc.scan_len = 8'd5;
      step("s37_enter");
      acks = 0; guard = 0;
      while (ifc.scan_ack && guard < 20) begin
        acks++; guard++;
        if (acks == 2) ifc.en = 1'b0;
        step("s37_shift");
      end
      chk_int("s37_ack_cycles", acks, 5);
      chk("s37_done_idle", outv, 8'b0100_1000);
      ifc.scan_req = 1'b0;

      // Async reset mid-shift: se_n_out high at once, no done pulse after.
      ifc.scan_req = 1'b1; ifc.scan_len = 8'd10;
      step("s37r_enter"); step("s37r_shift"); step("s37r_shift");
      chk_int("s37r_in_scan", int'(ifc.scan_ack), 1);
      do_reset();
      step("s37r_post");
      chk_int("s37r_no_done", int'(ifc.scan_done), 0);
    end

    // Random traffic against the model.
    do_reset();
    ifc.en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) ifc.en = ~ifc.en;
      else if (!ifc.en && $urandom_range(0, 3) == 0) ifc.en = 1'b1;
      if (!ifc.scan_req && $urandom_range(0, 29) == 0) ifc.scan_req = 1'b1;
      else if (ifc.scan_req && ifc.scan_done && $urandom_range(0, 3) != 0) ifc.scan_req = 1'b0;
      else if (ifc.scan_req && $urandom_range(0, 49) == 0) ifc.scan_req = 1'b0;
      ifc.scan_len = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        ifc.en = 1'b1;
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
